// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, FSM states, latched frame config.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10,
    PAR_MARK = 2'b11
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Per-frame line format captured at acceptance.
  typedef struct packed {
    parity_e parity;
    logic    stop2;
  } tx_cfg_t;

  // Parity bit from the XOR-reduction of the data bits.
  function automatic logic parity_bit(input parity_e mode, input logic red_xor);
    logic p;
    case (mode)
      PAR_EVEN: p = red_xor;
      PAR_ODD:  p = ~red_xor;
      default:  p = 1'b1;  // mark; PAR_NONE never sends a parity bit
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter: bit_done pulses in the last cycle of each bit period.
module uart_bit_timer #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] period,  // cycles per bit, must be >= 1
  output logic             bit_done
);

  logic [DIV_W-1:0] cnt_q;

  assign bit_done = en & (cnt_q == '0);

  // Load restarts the period; while enabled the counter reloads itself each bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= period - DIV_W'(1);
    end else if (en) begin
      cnt_q <= (cnt_q == '0) ? period - DIV_W'(1) : cnt_q - DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: start, DATA_W data bits LSB first, optional parity, 1-2 stops.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  div,
  input  logic [1:0]        parity_mode,
  input  logic              stop2,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              txd,
  output logic              busy
);

  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
    $error("uart_tx_core: DATA_W must be within 5..9");
  end

  localparam int                IDX_W    = $clog2(DATA_W);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_W - 1);

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  tx_cfg_t           cfg_q, cfg_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              stop_idx_q, stop_idx_d;
  logic              txd_q, txd_d;
  logic              armed_q;  // holds s_ready low until the first edge after reset

  logic              bit_done;
  logic              accept;
  logic              last_stop;
  logic [DIV_W-1:0]  div_eff;

  assign div_eff   = (div == '0) ? DIV_W'(1) : div;
  assign last_stop = (stop_idx_q == cfg_q.stop2);
  assign accept    = s_valid & s_ready;

  // Ready while idle, and in the final cycle of the final stop bit so frames abut.
  assign s_ready = armed_q & ((state_q == ST_IDLE) |
                              ((state_q == ST_STOP) & bit_done & last_stop));
  assign busy    = (state_q != ST_IDLE);
  assign txd     = txd_q;

  uart_bit_timer #(.DIV_W(DIV_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .en       (busy),
    .period   (accept ? div_eff : div_q),
    .bit_done (bit_done)
  );

  // Next-state, bit sequencing, and the next line level.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    cfg_d      = cfg_q;
    div_d      = div_q;
    idx_d      = idx_q;
    stop_idx_d = stop_idx_q;
    txd_d      = 1'b1;

    case (state_q)
      ST_START: begin
        if (bit_done) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          if (idx_q == LAST_IDX) begin
            state_d    = (cfg_q.parity != PAR_NONE) ? ST_PARITY : ST_STOP;
            stop_idx_d = 1'b0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) begin
          state_d    = ST_STOP;
          stop_idx_d = 1'b0;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          if (last_stop) state_d    = ST_IDLE;
          else           stop_idx_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Acceptance only happens in IDLE or the last stop cycle; it overrides both.
    if (accept) begin
      state_d      = ST_START;
      data_d       = s_data;
      cfg_d.parity = parity_e'(parity_mode);
      cfg_d.stop2  = stop2;
      div_d        = div_eff;
      idx_d        = '0;
      stop_idx_d   = 1'b0;
    end

    case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = data_d[idx_d];
      ST_PARITY: txd_d = parity_bit(cfg_d.parity, ^data_d);
      default:   txd_d = 1'b1;
    endcase
  end

  // State, latched frame and registered line output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      cfg_q      <= '{parity: PAR_NONE, stop2: 1'b0};
      div_q      <= '0;
      idx_q      <= '0;
      stop_idx_q <= 1'b0;
      txd_q      <= 1'b1;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      cfg_q      <= cfg_d;
      div_q      <= div_d;
      idx_q      <= idx_d;
      stop_idx_q <= stop_idx_d;
      txd_q      <= txd_d;
      armed_q    <= 1'b1;
    end
  end

endmodule
